// File: rtl/sap1_datapath.sv
// sap1_datapath: SAP-1 datapath executing control-word register transfers over one 8-bit bus
module sap1_datapath #(
  parameter int    DATA_W   = 8,
  parameter int    ADDR_W   = 4,
  parameter string RAM_INIT = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic              flag_c,
  output logic              flag_z,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              bus_err,
  output logic [DATA_W-1:0] bus_mon
);
  logic fi, j, co, ce, oi, bi, su, eo, ai, ao, ii, io, ri, ro, mi, hlt;
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir, a, b, bus;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W:0]   res9;
  logic              conflict, act;
  assign {fi, j, co, ce, oi, bi, su, eo, ai, ao, ii, io, ri, ro, mi, hlt} = ctrl;
  assign res9 = {1'b0, a} + {1'b0, su ? ~b : b} + {{DATA_W{1'b0}}, su};
  assign conflict = !$onehot0({co, ao, eo, io, ro});
  assign act = !halted && !conflict;
  always_comb
    bus = conflict ? '0 :
          ({DATA_W{co}} & {{(DATA_W-ADDR_W){1'b0}}, pc}) |
          ({DATA_W{ao}} & a) |
          ({DATA_W{eo}} & res9[DATA_W-1:0]) |
          ({DATA_W{io}} & {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]}) |
          ({DATA_W{ro}} & mem[mar]);
  assign bus_mon = bus;
  assign opcode = ir[DATA_W-1:DATA_W-4];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      mar <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      halted <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      out_valid <= act && oi;
      bus_err <= !halted && conflict;
      if (act) begin
        if (mi) mar <= bus[ADDR_W-1:0];
        if (ii) ir <= bus;
        if (ai) a <= bus;
        if (bi) b <= bus;
        if (oi) out_data <= bus;
        if (fi) begin
          flag_c <= res9[DATA_W];
          flag_z <= res9[DATA_W-1:0] == '0;
        end
        if (j) pc <= bus[ADDR_W-1:0];
        else if (ce) pc <= pc + ADDR_W'(1);
        if (hlt) halted <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (prog_we) mem[prog_addr] <= prog_data;
    else if (act && ri && !rst) mem[mar] <= bus;
endmodule

// File: tb/tb_sap1_datapath.sv
// tb_sap1_datapath: random and directed stimulus against a behavioural SAP-1 datapath model
module tb_sap1_datapath;
  localparam logic [15:0] FI = 16'h8000, J = 16'h4000, CO = 16'h2000, CE = 16'h1000;
  localparam logic [15:0] OI = 16'h0800, BI = 16'h0400, SU = 16'h0200, EO = 16'h0100;
  localparam logic [15:0] AI = 16'h0080, AO = 16'h0040, II = 16'h0020, IO = 16'h0010;
  localparam logic [15:0] RI = 16'h0008, RO = 16'h0004, MI = 16'h0002, HLT = 16'h0001;
  logic clk = 0, rst = 0, prog_we = 0;
  logic [15:0] ctrl = 0;
  logic [3:0] prog_addr = 0, opcode;
  logic [7:0] prog_data = 0, out_data, bus_mon;
  logic flag_c, flag_z, out_valid, halted, bus_err;
  int vectors = 0, miscompares = 0;
  bit chk_en = 0;
  int m_pc, m_mar, m_ir, m_a, m_b, m_out;
  bit m_c, m_z, m_ov, m_halt, m_err;
  int m_mem [16];
  sap1_datapath dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .out_data(out_data), .out_valid(out_valid), .halted(halted), .bus_err(bus_err),
    .bus_mon(bus_mon)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  function automatic int drivers(input logic [15:0] c);
    return int'(c[13]) + int'(c[6]) + int'(c[8]) + int'(c[4]) + int'(c[2]);
  endfunction
  function automatic int alu_raw(input logic [15:0] c);
    return c[9] ? m_a - m_b : m_a + m_b;
  endfunction
  function automatic int alu_res(input logic [15:0] c);
    return alu_raw(c) & 255;
  endfunction
  function automatic bit alu_carry(input logic [15:0] c);
    return c[9] ? m_a >= m_b : alu_raw(c) > 255;
  endfunction
  function automatic int m_bus(input logic [15:0] c);
    if (drivers(c) > 1) return 0;
    if (c[13]) return m_pc;
    if (c[6]) return m_a;
    if (c[8]) return alu_res(c);
    if (c[4]) return m_ir % 16;
    if (c[2]) return m_mem[m_mar];
    return 0;
  endfunction
  task automatic model_reset();
    {m_pc, m_mar, m_ir, m_a, m_b, m_out} = '0;
    {m_c, m_z, m_ov, m_halt, m_err} = '0;
  endtask
  task automatic model_tick();
    bit conf, cy, zr;
    int bv, res, old_mar;
    if (rst) return;
    conf = drivers(ctrl) > 1;
    bv = m_bus(ctrl);
    res = alu_res(ctrl);
    cy = alu_carry(ctrl);
    zr = res == 0;
    old_mar = m_mar;
    m_err = !m_halt && conf;
    m_ov = !m_halt && !conf && ctrl[11];
    if (!m_halt && !conf) begin
      if (ctrl[3] && !prog_we) m_mem[old_mar] = bv;
      if (ctrl[1]) m_mar = bv % 16;
      if (ctrl[5]) m_ir = bv;
      if (ctrl[7]) m_a = bv;
      if (ctrl[10]) m_b = bv;
      if (ctrl[11]) m_out = bv;
      if (ctrl[15]) begin m_c = cy; m_z = zr; end
      if (ctrl[14]) m_pc = bv % 16;
      else if (ctrl[12]) m_pc = (m_pc + 1) % 16;
      if (ctrl[0]) m_halt = 1;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
  endtask
  always @(negedge clk)
    if (chk_en) begin
      check("opcode", opcode, m_ir / 16);
      check("flag_c", flag_c, m_c);
      check("flag_z", flag_z, m_z);
      check("out_data", out_data, m_out);
      check("out_valid", out_valid, m_ov);
      check("halted", halted, m_halt);
      check("bus_err", bus_err, m_err);
      check("bus_mon", bus_mon, m_bus(ctrl));
    end
  task automatic tick();
    @(posedge clk);
    model_tick();
    #2;
  endtask
  task automatic step(input logic [15:0] c, input logic pwe = 0,
                      input logic [3:0] pa = 0, input logic [7:0] pd = 0);
    ctrl = c; prog_we = pwe; prog_addr = pa; prog_data = pd;
    tick();
  endtask
  task automatic prog(input logic [3:0] pa, input logic [7:0] pd);
    step(16'h0, 1'b1, pa, pd);
  endtask
  task automatic peek(input logic [15:0] c, input string name, input int exp);
    ctrl = c; prog_we = 0;
    #1 check(name, bus_mon, exp);
  endtask
  task automatic do_reset();
    ctrl = 0; prog_we = 0; rst = 1;
    model_reset();
    @(posedge clk); #2;
    rst = 0;
  endtask
  function automatic logic [15:0] rand_ctrl();
    logic [15:0] drv [5] = '{CO, AO, EO, IO, RO};
    logic [15:0] c;
    c = 16'($urandom & $urandom) & (FI | J | CE | OI | BI | SU | AI | II | RI | MI);
    if ($urandom_range(0, 5) != 0) c |= drv[$urandom_range(0, 4)];
    if ($urandom_range(0, 9) == 0) c |= drv[$urandom_range(0, 4)];
    if ($urandom_range(0, 149) == 0) c |= HLT;
    return c;
  endfunction
  initial begin
    #1 rst = 1;
    model_reset();
    #1;
    check("rst_opcode", opcode, 0);
    check("rst_halted", halted, 0);
    check("rst_out", out_data, 0);
    @(posedge clk); #2;
    rst = 0;
    chk_en = 1;
    for (int i = 0; i < 16; i++) prog(4'(i), 8'($urandom));
    prog(0, 8'h1E); prog(1, 8'hF0); prog(2, 8'h20); prog(3, 8'h2A);
    prog(4, 8'h13); prog(5, 8'h05); prog(6, 8'h67); prog(7, 8'h6F);
    step(CO | MI); step(RO | II | CE);
    check("fetch_opcode", opcode, 4'h1);
    peek(CO, "fetch_pc", 8'h01);
    step(CO | MI); step(RO | AI | CE); step(CO | MI); step(RO | BI | CE);
    step(EO | AI | FI);
    check("add_c", flag_c, 1);
    check("add_z", flag_z, 0);
    peek(AO, "add_a", 8'h10);
    step(CE); step(CO | MI); step(RO | II | CE); step(MI | IO);
    peek(RO | AI, "rd_bus", 8'h2A);
    tick();
    peek(AO, "rd_a", 8'h2A);
    step(CO | MI); step(RO | AI | BI | CE); step(SU | EO | AI | FI);
    check("sub_c", flag_c, 1);
    check("sub_z", flag_z, 1);
    peek(AO, "sub_a", 8'h00);
    step(CO | MI); step(RO | II); step(J | IO);
    peek(CO, "jmp_pc", 8'h07);
    step(J | CE | IO);
    peek(CO, "jce_pc", 8'h07);
    step(CO | MI); step(RO | II); step(J | IO);
    peek(CO, "pc_f", 8'h0F);
    step(CE);
    peek(CO, "pc_wrap", 8'h00);
    prog(0, 8'h55); step(CO | MI); step(RO | AI);
    peek(CO | AO | AI, "conf_bus", 8'h00);
    tick();
    check("conf_err", bus_err, 1);
    peek(AO, "conf_a", 8'h55);
    step(16'h0);
    check("conf_err_end", bus_err, 0);
    prog(0, 8'h99); step(RO | AI); step(AO | OI);
    check("oi_data", out_data, 8'h99);
    check("oi_valid", out_valid, 1);
    step(16'h0);
    check("oi_valid_end", out_valid, 0);
    step(HLT | CE);
    check("hlt", halted, 1);
    prog(0, 8'h11); step(RO | AI);
    peek(AO, "hlt_a", 8'h99);
    peek(RO, "hlt_prog", 8'h11);
    ctrl = 0;
    rst = 1;
    model_reset();
    #1;
    check("mid_rst_halted", halted, 0);
    check("mid_rst_opcode", opcode, 0);
    check("mid_rst_c", flag_c, 0);
    check("mid_rst_out", out_data, 0);
    @(posedge clk); #2;
    rst = 0;
    for (int e = 0; e < 6; e++) begin
      for (int n = 0; n < 300; n++)
        step(rand_ctrl(), $urandom_range(0, 9) == 0, 4'($urandom), 8'($urandom));
      do_reset();
    end
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
